// File: rtl/axi_bus_master_arbiter.sv
// AXI bus master arbiter: muxes M_NUM masters' AW/W and AR channels onto one bus.
// Ports: per-master M_{WR_ADDR,WR_DATA,RD_ADDR}_*, bus-side S_*, WR_GRANT, RD_GRANT.
module axi_bus_master_arbiter #(
  parameter int M_NUM = 4,
  parameter int IW    = $clog2(M_NUM)
) (
  input  logic               B_CLK,
  input  logic               B_RSTN,
  input  logic [M_NUM-1:0]    M_WR_ADDR_VALID,
  output logic [M_NUM-1:0]    M_WR_ADDR_READY,
  input  logic [M_NUM*44-1:0] M_WR_ADDR_INFO,
  input  logic [M_NUM-1:0]    M_WR_DATA_VALID,
  output logic [M_NUM-1:0]    M_WR_DATA_READY,
  input  logic [M_NUM*37-1:0] M_WR_DATA_INFO,
  input  logic [M_NUM-1:0]    M_RD_ADDR_VALID,
  output logic [M_NUM-1:0]    M_RD_ADDR_READY,
  input  logic [M_NUM*44-1:0] M_RD_ADDR_INFO,
  output logic               S_WR_ADDR_VALID,
  input  logic               S_WR_ADDR_READY,
  output logic [43:0]        S_WR_ADDR_INFO,
  output logic               S_WR_DATA_VALID,
  input  logic               S_WR_DATA_READY,
  output logic [36:0]        S_WR_DATA_INFO,
  output logic               S_RD_ADDR_VALID,
  input  logic               S_RD_ADDR_READY,
  output logic [43:0]        S_RD_ADDR_INFO,
  output logic [M_NUM-1:0]    WR_GRANT,
  output logic [M_NUM-1:0]    RD_GRANT
);

  localparam int AW_W = 44;
  localparam int W_W  = 37;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_ADDR
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [IW-1:0] wr_ptr, wr_ptr_n;
  logic [IW-1:0] wr_idx, wr_idx_n;
  logic [IW-1:0] rd_ptr, rd_ptr_n;
  logic [IW-1:0] rd_idx, rd_idx_n;

  logic [AW_W-1:0] aw_info [M_NUM];
  logic [W_W-1:0]  w_info  [M_NUM];
  logic [AW_W-1:0] ar_info [M_NUM];

  logic aw_fire;
  logic w_fire;
  logic w_last;
  logic ar_fire;

  // First requester at or after ptr, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [M_NUM-1:0] req,
    input logic [IW-1:0]    ptr
  );
    logic [IW-1:0] sel;
    logic [IW-1:0] k;
    logic          hit;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < M_NUM; i++) begin
      k = IW'((int'(ptr) + i) % M_NUM);
      if (!hit && req[k]) begin
        sel = k;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IW-1:0] rr_inc(
    input logic [IW-1:0] i
  );
    return (int'(i) == M_NUM - 1) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < M_NUM; i++) begin
      aw_info[i] = M_WR_ADDR_INFO[i*AW_W +: AW_W];
      w_info[i]  = M_WR_DATA_INFO[i*W_W +: W_W];
      ar_info[i] = M_RD_ADDR_INFO[i*AW_W +: AW_W];
    end
  end

  assign aw_fire = (w_state == W_ADDR) &&
                   M_WR_ADDR_VALID[wr_idx] &&
                   S_WR_ADDR_READY;
  assign w_fire  = (w_state == W_DATA) &&
                   M_WR_DATA_VALID[wr_idx] &&
                   S_WR_DATA_READY;
  assign w_last  = w_info[wr_idx][0];
  assign ar_fire = (r_state == R_ADDR) &&
                   M_RD_ADDR_VALID[rd_idx] &&
                   S_RD_ADDR_READY;

  // Write path state
  always_ff @(posedge B_CLK or negedge B_RSTN) begin
    if (!B_RSTN) begin
      w_state <= W_IDLE;
      wr_ptr  <= '0;
      wr_idx  <= '0;
    end else begin
      w_state <= w_next;
      wr_ptr  <= wr_ptr_n;
      wr_idx  <= wr_idx_n;
    end
  end

  always_comb begin
    w_next   = w_state;
    wr_ptr_n = wr_ptr;
    wr_idx_n = wr_idx;
    unique case (w_state)
      W_IDLE: begin
        if (|M_WR_ADDR_VALID) begin
          w_next   = W_ADDR;
          wr_idx_n = rr_pick(M_WR_ADDR_VALID, wr_ptr);
        end
      end
      W_ADDR: begin
        if (aw_fire) w_next = W_DATA;
      end
      W_DATA: begin
        // Only LAST ends the burst; LEN is not tracked.
        if (w_fire && w_last) begin
          w_next   = W_IDLE;
          wr_ptr_n = rr_inc(wr_idx);
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    M_WR_ADDR_READY = '0;
    M_WR_DATA_READY = '0;
    S_WR_ADDR_VALID = 1'b0;
    S_WR_ADDR_INFO  = '0;
    S_WR_DATA_VALID = 1'b0;
    S_WR_DATA_INFO  = '0;
    WR_GRANT        = '0;
    unique case (w_state)
      W_IDLE: ;
      W_ADDR: begin
        WR_GRANT        = M_NUM'(1) << wr_idx;
        S_WR_ADDR_VALID = M_WR_ADDR_VALID[wr_idx];
        if (M_WR_ADDR_VALID[wr_idx])
          S_WR_ADDR_INFO = aw_info[wr_idx];
        M_WR_ADDR_READY[wr_idx] = S_WR_ADDR_READY;
      end
      W_DATA: begin
        WR_GRANT        = M_NUM'(1) << wr_idx;
        S_WR_DATA_VALID = M_WR_DATA_VALID[wr_idx];
        if (M_WR_DATA_VALID[wr_idx])
          S_WR_DATA_INFO = w_info[wr_idx];
        M_WR_DATA_READY[wr_idx] = S_WR_DATA_READY;
      end
      default: ;
    endcase
  end

  // Read path state
  always_ff @(posedge B_CLK or negedge B_RSTN) begin
    if (!B_RSTN) begin
      r_state <= R_IDLE;
      rd_ptr  <= '0;
      rd_idx  <= '0;
    end else begin
      r_state <= r_next;
      rd_ptr  <= rd_ptr_n;
      rd_idx  <= rd_idx_n;
    end
  end

  always_comb begin
    r_next   = r_state;
    rd_ptr_n = rd_ptr;
    rd_idx_n = rd_idx;
    unique case (r_state)
      R_IDLE: begin
        if (|M_RD_ADDR_VALID) begin
          r_next   = R_ADDR;
          rd_idx_n = rr_pick(M_RD_ADDR_VALID, rd_ptr);
        end
      end
      R_ADDR: begin
        if (ar_fire) begin
          r_next   = R_IDLE;
          rd_ptr_n = rr_inc(rd_idx);
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    M_RD_ADDR_READY = '0;
    S_RD_ADDR_VALID = 1'b0;
    S_RD_ADDR_INFO  = '0;
    RD_GRANT        = '0;
    unique case (r_state)
      R_IDLE: ;
      R_ADDR: begin
        RD_GRANT        = M_NUM'(1) << rd_idx;
        S_RD_ADDR_VALID = M_RD_ADDR_VALID[rd_idx];
        if (M_RD_ADDR_VALID[rd_idx])
          S_RD_ADDR_INFO = ar_info[rd_idx];
        M_RD_ADDR_READY[rd_idx] = S_RD_ADDR_READY;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_bus_master_arbiter.md
AXI_BUS_MASTER_ARBITER -- requirements
Module: axi_bus_master_arbiter

Interface
REQ-001 SHALL have parameter: M_NUM, 4, number of requesting masters; index width IW = clog2(M_NUM) = 2.
REQ-002 SHALL have port: B_CLK  input  1  bus clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port: B_RSTN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: M_WR_ADDR_VALID  input  M_NUM  per-master AW valid.
REQ-005 SHALL have port: M_WR_ADDR_READY  output  M_NUM  per-master AW ready.
REQ-006 SHALL have port: M_WR_ADDR_INFO  input  M_NUM*44  per-master {ID[1:0], ADDR[31:0], LEN[7:0], BURST[1:0]}, master i at bits [44i+43:44i].
REQ-007 SHALL have port: M_WR_DATA_VALID  input  M_NUM  per-master W valid.
REQ-008 SHALL have port: M_WR_DATA_READY  output  M_NUM  per-master W ready.
REQ-009 SHALL have port: M_WR_DATA_INFO  input  M_NUM*37  per-master {DATA[31:0], STRB[3:0], LAST}, LAST is bit 37i.
REQ-010 SHALL have port: M_RD_ADDR_VALID / M_RD_ADDR_READY / M_RD_ADDR_INFO  input / output / input  M_NUM / M_NUM / M_NUM*44  per-master AR channel, same packing as AW.
REQ-011 SHALL have port: S_WR_ADDR_VALID / S_WR_ADDR_READY / S_WR_ADDR_INFO  output / input / output  1 / 1 / 44  bus-side AW.
REQ-012 SHALL have port: S_WR_DATA_VALID / S_WR_DATA_READY / S_WR_DATA_INFO  output / input / output  1 / 1 / 37  bus-side W.
REQ-013 SHALL have port: S_RD_ADDR_VALID / S_RD_ADDR_READY / S_RD_ADDR_INFO  output / input / output  1 / 1 / 44  bus-side AR.
REQ-014 SHALL have port: WR_GRANT  output  M_NUM  one-hot write grant, zero when write FSM idle.
REQ-015 SHALL have port: RD_GRANT  output  M_NUM  one-hot read grant, zero when read FSM idle.

Function
REQ-016 Write path SHALL use FSM W_IDLE -> W_ADDR -> W_DATA -> W_IDLE; read path SHALL use independent FSM R_IDLE -> R_ADDR -> R_IDLE; both run concurrently.
REQ-017 In W_IDLE with any M_WR_ADDR_VALID set, SHALL register a grant to the first requester at or after wr_ptr (round-robin, wrapping M_NUM-1 -> 0) and enter W_ADDR next cycle; request-to-S_WR_ADDR_VALID latency exactly 1 cycle.
REQ-018 In W_ADDR, S_WR_ADDR_VALID/INFO SHALL mirror granted master's AW valid/info and its M_WR_ADDR_READY SHALL mirror S_WR_ADDR_READY; handshake -> W_DATA.
REQ-019 In W_DATA, S_WR_DATA_VALID/INFO SHALL mirror granted master's W, its M_WR_DATA_READY mirrors S_WR_DATA_READY; handshake with LAST=1 -> W_IDLE and wr_ptr <= granted index + 1 (mod M_NUM).
REQ-020 Read path: R_IDLE arbitrates M_RD_ADDR_VALID round-robin from rd_ptr with 1-cycle latency; R_ADDR forwards AR; handshake -> R_IDLE, rd_ptr <= granted+1 (mod M_NUM).
REQ-021 Non-granted masters' READY bits SHALL be 0; all READY bits 0 in idle states; W readies 0 outside W_DATA.
REQ-022 Bus-side INFO outputs SHALL be all-zero whenever the matching S_*_VALID is 0.
REQ-023 Grant SHALL be held until the completing handshake even if the granted master deasserts VALID; no timeout or preemption.
REQ-024 LAST alone SHALL terminate a write burst; LEN is not counted; at least one idle cycle separates consecutive write grants and consecutive read grants.
REQ-025 W beats presented by any master outside W_DATA SHALL be ignored (READY=0), never forwarded.
REQ-026 Simultaneous requests SHALL be resolved solely by pointer position; single requester SHALL be granted regardless of pointer.

Reset
REQ-027 On B_RSTN low, asynchronously: both FSMs to idle, wr_ptr=rd_ptr=0, WR_GRANT=RD_GRANT=0, all READY and S_*_VALID outputs 0, S_*_INFO 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further beats forwarded; after release the first arbitration starts from master 0.

Verification
REQ-029 After reset, M_WR_ADDR_VALID=4'b1111 held, each burst LEN=0 with LAST -> grants in order 0,1,2,3,0, WR_GRANT one-hot each time.
REQ-030 Master 2 AW ADDR=0x0000_1000 LEN=3, four W beats DATA=0xA0..0xA3, S_*_READY toggling 1/0 -> S side sees exactly that AW then 4 beats in order, LAST only on 0xA3, then W_IDLE.
REQ-031 During master 1 write burst, master 3 presents W beat -> M_WR_DATA_READY[3]=0 and its data never appears on S_WR_DATA_INFO.
REQ-032 Concurrent: master 0 writing, master 3 AR ADDR=0x2000 -> S_RD_ADDR_VALID one cycle after request, ARs complete without waiting for write LAST.
REQ-033 B_RSTN pulsed low in W_DATA after 2 of 4 beats -> all outputs 0 same cycle; after release M_WR_ADDR_VALID=4'b1010 grants master 1 first.
